// File: rtl/perceptron_pkg.sv
// Shared types and default sizing for the perceptron weight-table controller.
package perceptron_pkg;
  localparam int PN_DEFAULT    = 62;
  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 64;
  localparam int LANES_DEFAULT = 8;
  localparam int THETA_DEFAULT = 133;

  typedef logic signed [WIDTH_DEFAULT-1:0] weight_t;
  typedef weight_t row_t [PN_DEFAULT];
  typedef logic signed [31:0] sum_t;

  typedef enum logic [2:0] {
    IDLE, READ, CAPT, ACC, RESP, WRITE, DONE
  } ctrl_state_e;
endpackage

// File: rtl/perceptron_row_update.sv
// Saturating +/-1 training step applied to every weight of one row; purely combinational.
module perceptron_row_update #(
  parameter int PN    = 62,
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] row_i [PN],
  input  logic [PN-1:0]           history_i,
  input  logic                    outcome_i,
  output logic signed [WIDTH-1:0] row_o [PN]
);
  localparam logic signed [WIDTH-1:0] WMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] WMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] WONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    for (int i = 0; i < PN; i++) begin
      row_o[i] = row_i[i];
      if (history_i[i] == outcome_i) begin
        if (row_i[i] != WMAX) row_o[i] = row_i[i] + WONE;
      end else begin
        if (row_i[i] != WMIN) row_o[i] = row_i[i] - WONE;
      end
    end
  end
endmodule

// File: rtl/perceptron_ctrl.sv
// Weight-table sequencer: one request at a time, training wins ties; predict returns after 3+K
// cycles, a train update finishes in 4, a train skip in 1. Requesters wait on ready while busy.
module perceptron_ctrl
  import perceptron_pkg::*;
#(
  parameter int PERCEPTRON_NUMBER = PN_DEFAULT,
  parameter int WIDTH             = WIDTH_DEFAULT,
  parameter int TABLE_DEPTH       = DEPTH_DEFAULT,
  parameter int LANES             = LANES_DEFAULT,
  parameter int THETA             = THETA_DEFAULT,
  localparam int IDX_W            = $clog2(TABLE_DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pred_req_valid,
  output logic                               pred_req_ready,
  input  logic [IDX_W-1:0]                   pred_idx,
  input  logic [PERCEPTRON_NUMBER-1:0]       pred_history,
  output logic                               pred_resp_valid,
  output logic                               pred_resp_taken,
  output logic signed [31:0]                 pred_resp_sum,
  input  logic                               train_req_valid,
  output logic                               train_req_ready,
  input  logic [IDX_W-1:0]                   train_idx,
  input  logic [PERCEPTRON_NUMBER-1:0]       train_history,
  input  logic                               train_outcome,
  input  logic                               train_pred,
  input  logic signed [31:0]                 train_sum,
  output logic                               train_done,
  output logic                               wt_rd_en,
  output logic [IDX_W-1:0]                   wt_addr,
  input  logic [PERCEPTRON_NUMBER*WIDTH-1:0] wt_rd_data,
  output logic                               wt_wr_en,
  output logic [PERCEPTRON_NUMBER*WIDTH-1:0] wt_wr_data
);
  localparam int K  = (PERCEPTRON_NUMBER + LANES - 1) / LANES;
  localparam int CW = $clog2(K + 1);

  ctrl_state_e                  state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [PERCEPTRON_NUMBER-1:0] hist_q;
  logic                         outcome_q, train_q;
  logic signed [WIDTH-1:0]      row_q   [PERCEPTRON_NUMBER];
  logic signed [WIDTH-1:0]      row_upd [PERCEPTRON_NUMBER];
  sum_t                         sum_q, acc_sum_d, resp_sum_q;
  logic [CW-1:0]                chunk_q;
  logic                         resp_valid_q, resp_taken_q, done_q, rd_en_q, wr_en_q;
  logic                         train_upd;

  assign train_req_ready = !rst_n && (state_q == IDLE);
  assign pred_req_ready  = train_req_ready && !train_req_valid;
  assign train_upd = (train_pred != train_outcome) ||
                     ((train_sum >= -THETA) && (train_sum <= THETA));

  // Only the lanes belonging to the current chunk contribute; lanes past the row end never exist.
  always_comb begin
    acc_sum_d = sum_q;
    for (int i = 0; i < PERCEPTRON_NUMBER; i++) begin
      if ((i / LANES) == int'(chunk_q)) begin
        if (hist_q[i]) acc_sum_d = acc_sum_d + sum_t'(row_q[i]);
        else           acc_sum_d = acc_sum_d - sum_t'(row_q[i]);
      end
    end
  end

  perceptron_row_update #(.PN(PERCEPTRON_NUMBER), .WIDTH(WIDTH)) u_row_update (
    .row_i     (row_q),
    .history_i (hist_q),
    .outcome_i (outcome_q),
    .row_o     (row_upd)
  );

  for (genvar g = 0; g < PERCEPTRON_NUMBER; g++) begin : g_wr
    assign wt_wr_data[g*WIDTH +: WIDTH] = row_upd[g];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hist_q       <= '0;
      outcome_q    <= 1'b0;
      train_q      <= 1'b0;
      sum_q        <= '0;
      resp_sum_q   <= '0;
      chunk_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      for (int i = 0; i < PERCEPTRON_NUMBER; i++) row_q[i] <= '0;
    end else begin
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (train_req_valid) begin
            idx_q     <= train_idx;
            hist_q    <= train_history;
            outcome_q <= train_outcome;
            train_q   <= 1'b1;
            if (train_upd) begin
              state_q <= READ;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else if (pred_req_valid) begin
            idx_q   <= pred_idx;
            hist_q  <= pred_history;
            train_q <= 1'b0;
            state_q <= READ;
            rd_en_q <= 1'b1;
          end
        end
        READ: state_q <= CAPT;
        CAPT: begin
          for (int i = 0; i < PERCEPTRON_NUMBER; i++) row_q[i] <= wt_rd_data[i*WIDTH +: WIDTH];
          sum_q   <= '0;
          chunk_q <= '0;
          if (train_q) begin
            state_q <= WRITE;
            wr_en_q <= 1'b1;
          end else begin
            state_q <= ACC;
          end
        end
        ACC: begin
          sum_q   <= acc_sum_d;
          chunk_q <= chunk_q + CW'(1);
          if (chunk_q == CW'(K - 1)) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_sum_q   <= acc_sum_d;
            resp_taken_q <= ~acc_sum_d[31];
          end
        end
        RESP: state_q <= IDLE;
        WRITE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pred_resp_valid = resp_valid_q;
  assign pred_resp_taken = resp_taken_q;
  assign pred_resp_sum   = resp_sum_q;
  assign train_done      = done_q;
  assign wt_rd_en        = rd_en_q;
  assign wt_wr_en        = wr_en_q;
  assign wt_addr         = idx_q;
endmodule

// File: tb/tb_perceptron_ctrl.sv
// Directed bench for perceptron_ctrl with a behavioural weight memory and a prediction scoreboard.
module tb_perceptron_ctrl;
  import perceptron_pkg::*;
  localparam int PN = 62, W = 8, IW = 6, WR = PN * W;

  logic clk = 1'b0;
  logic rst_n;
  logic pred_req_valid, pred_req_ready, pred_resp_valid, pred_resp_taken;
  logic [IW-1:0] pred_idx, train_idx, wt_addr;
  logic [PN-1:0] pred_history, train_history;
  logic signed [31:0] pred_resp_sum, train_sum;
  logic train_req_valid, train_req_ready, train_outcome, train_pred, train_done;
  logic wt_rd_en, wt_wr_en;
  logic [WR-1:0] wt_rd_data, wt_wr_data;

  perceptron_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .pred_req_valid(pred_req_valid), .pred_req_ready(pred_req_ready),
    .pred_idx(pred_idx), .pred_history(pred_history),
    .pred_resp_valid(pred_resp_valid), .pred_resp_taken(pred_resp_taken),
    .pred_resp_sum(pred_resp_sum),
    .train_req_valid(train_req_valid), .train_req_ready(train_req_ready),
    .train_idx(train_idx), .train_history(train_history), .train_outcome(train_outcome),
    .train_pred(train_pred), .train_sum(train_sum), .train_done(train_done),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_rd_data(wt_rd_data),
    .wt_wr_en(wt_wr_en), .wt_wr_data(wt_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [WR-1:0] obs, input logic [WR-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural single-port memory: read data appears the cycle after wt_rd_en.
  logic [WR-1:0] mem [64];
  logic pre_we = 1'b0;
  logic [IW-1:0] pre_addr = '0;
  logic [WR-1:0] pre_dat = '0;
  int rd_cnt = 0, wr_cnt = 0, rd_cyc = 0, wr_cyc = 0, overlap = 0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    if (wt_rd_en) begin
      wt_rd_data <= mem[wt_addr];
      rd_cnt <= rd_cnt + 1;
      rd_cyc <= cyc;
    end
    if (wt_wr_en) begin
      mem[wt_addr] <= wt_wr_data;
      wr_cnt <= wr_cnt + 1;
      wr_cyc <= cyc;
    end
    if (wt_rd_en && wt_wr_en) overlap <= overlap + 1;
  end

  sum_t exp_sum_q[$];
  int   exp_cyc_q[$];

  always begin
    @(posedge clk);
    #1;
    if (pred_resp_valid === 1'b1) begin
      if (exp_sum_q.size() == 0) begin
        chk("pred_unexpected", pred_resp_valid, 1'b0);
      end else begin
        sum_t s;
        int c;
        s = exp_sum_q.pop_front();
        c = exp_cyc_q.pop_front();
        chk("pred_sum", pred_resp_sum, s);
        chk("pred_taken", pred_resp_taken, (s >= 0));
        chk("pred_latency", cyc, c);
      end
    end
  end

  function automatic logic [WR-1:0] fill(input int v);
    logic [WR-1:0] f;
    for (int i = 0; i < PN; i++) f[i*W +: W] = W'(v);
    return f;
  endfunction

  function automatic sum_t dot(input logic [WR-1:0] r, input logic [PN-1:0] h);
    int s;
    logic signed [W-1:0] w;
    s = 0;
    for (int i = 0; i < PN; i++) begin
      w = r[i*W +: W];
      s += h[i] ? int'(w) : -int'(w);
    end
    return sum_t'(s);
  endfunction

  task automatic preload(input logic [IW-1:0] a, input logic [WR-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic do_pred(input logic [IW-1:0] a, input logic [PN-1:0] h, input sum_t e);
    @(negedge clk);
    chk("pred_ready", pred_req_ready, 1'b1);
    pred_req_valid = 1'b1; pred_idx = a; pred_history = h;
    exp_sum_q.push_back(e);
    exp_cyc_q.push_back(cyc + 11);
    @(negedge clk);
    pred_req_valid = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  task automatic do_train(input logic [IW-1:0] a, input logic [PN-1:0] h, input logic o,
                          input logic p, input logic signed [31:0] s, input bit upd,
                          input string tag);
    int k, rd0, wr0, seen;
    @(negedge clk);
    chk({tag, "_ready"}, train_req_ready, 1'b1);
    train_req_valid = 1'b1; train_idx = a; train_history = h;
    train_outcome = o; train_pred = p; train_sum = s;
    k = cyc; rd0 = rd_cnt; wr0 = wr_cnt; seen = -1;
    @(negedge clk);
    train_req_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (train_done === 1'b1 && seen < 0) seen = cyc;
      @(negedge clk);
    end
    chk({tag, "_done_cyc"}, seen, k + (upd ? 4 : 1));
    chk({tag, "_reads"}, rd_cnt - rd0, upd ? 1 : 0);
    chk({tag, "_writes"}, wr_cnt - wr0, upd ? 1 : 0);
    if (upd) begin
      chk({tag, "_rd_cyc"}, rd_cyc, k + 1);
      chk({tag, "_wr_cyc"}, wr_cyc, k + 3);
    end
  endtask

  initial begin
    logic [PN-1:0] h, heven;
    logic [WR-1:0] r, r2;
    sum_t s0;
    int k, first, seen;

    rst_n = 1'b1;
    pred_req_valid = 1'b0; pred_idx = '0; pred_history = '0;
    train_req_valid = 1'b0; train_idx = '0; train_history = '0;
    train_outcome = 1'b0; train_pred = 1'b0; train_sum = '0;

    preload(6'd3, fill(1));
    preload(6'd5, fill(0));
    preload(6'd6, fill(0));
    chk("rst_pred_ready", pred_req_ready, 1'b0);
    chk("rst_train_ready", train_req_ready, 1'b0);
    chk("rst_resp_valid", pred_resp_valid, 1'b0);
    chk("rst_resp_taken", pred_resp_taken, 1'b0);
    chk("rst_resp_sum", pred_resp_sum, 0);
    chk("rst_train_done", train_done, 1'b0);
    chk("rst_rd_en", wt_rd_en, 1'b0);
    chk("rst_wr_en", wt_wr_en, 1'b0);
    rst_n = 1'b0;

    do_pred(6'd3, {PN{1'b1}}, 62);
    do_pred(6'd3, {PN{1'b0}}, -62);

    // Simultaneous valids: training goes first, predict waits until IDLE returns.
    @(negedge clk);
    train_req_valid = 1'b1; train_idx = 6'd5; train_history = {PN{1'b1}};
    train_outcome = 1'b1; train_pred = 1'b0; train_sum = 0;
    pred_req_valid = 1'b1; pred_idx = 6'd3; pred_history = {PN{1'b1}};
    k = cyc;
    #1;
    chk("simul_pred_ready", pred_req_ready, 1'b0);
    chk("simul_train_ready", train_req_ready, 1'b1);
    @(negedge clk);
    train_req_valid = 1'b0;
    first = -1; seen = -1;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (train_done === 1'b1 && seen < 0) seen = cyc;
      if (pred_req_ready === 1'b1) begin
        first = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("simul_train_done", seen, k + 4);
    chk("simul_pred_accept", first, k + 5);
    exp_sum_q.push_back(62);
    exp_cyc_q.push_back(first + 11);
    @(negedge clk);
    pred_req_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk_row("simul_row5", mem[5], fill(1));

    do_train(6'd6, {PN{1'b1}}, 1'b1, 1'b1, 200, 1'b0, "skip200");
    do_train(6'd6, {PN{1'b1}}, 1'b1, 1'b1, 133, 1'b1, "upd133");
    chk_row("upd133_row", mem[6], fill(1));
    do_train(6'd6, {PN{1'b1}}, 1'b0, 1'b0, -134, 1'b0, "skipn134");
    do_train(6'd6, {PN{1'b0}}, 1'b0, 1'b0, -133, 1'b1, "updn133");
    chk_row("updn133_row", mem[6], fill(2));

    for (int i = 0; i < PN; i++) begin
      heven[i] = (i % 2 == 0);
      r[i*W +: W]  = (i % 2 == 0) ? 8'sd127 : -8'sd128;
      r2[i*W +: W] = (i % 2 == 0) ? 8'sd126 : -8'sd127;
    end
    preload(6'd7, r);
    do_train(6'd7, heven, 1'b1, 1'b1, 0, 1'b1, "sat_keep");
    chk_row("sat_keep_row", mem[7], r);
    do_train(6'd7, ~heven, 1'b1, 1'b0, 0, 1'b1, "sat_move");
    chk_row("sat_move_row", mem[7], r2);
    do_pred(6'd7, heven, dot(r2, heven));

    for (int i = 0; i < PN; i++) r[i*W +: W] = W'(int'($urandom_range(0, 100)) - 50);
    h = PN'({$urandom(), $urandom()});
    preload(6'd8, r);
    s0 = dot(r, h);
    do_pred(6'd8, h, s0);
    do_train(6'd8, h, 1'b0, 1'b1, 500, 1'b1, "mis500");
    do_pred(6'd8, h, s0 - 62);

    do_pred(6'd3, {PN{1'b1}}, 62);

    // Reset while accumulating: the in-flight predict must vanish.
    @(negedge clk);
    pred_req_valid = 1'b1; pred_idx = 6'd3; pred_history = {PN{1'b1}};
    k = wr_cnt;
    @(negedge clk);
    pred_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_pred_ready", pred_req_ready, 1'b0);
    chk("midrst_train_ready", train_req_ready, 1'b0);
    chk("midrst_resp_valid", pred_resp_valid, 1'b0);
    chk("midrst_resp_taken", pred_resp_taken, 1'b0);
    chk("midrst_resp_sum", pred_resp_sum, 0);
    chk("midrst_train_done", train_done, 1'b0);
    chk("midrst_rd_en", wt_rd_en, 1'b0);
    chk("midrst_wr_en", wt_wr_en, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    do_pred(6'd3, {PN{1'b1}}, 62);
    chk("midrst_no_write", wr_cnt - k, 0);

    repeat (4) @(negedge clk);
    chk("sb_empty", exp_sum_q.size(), 0);
    chk("rd_wr_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/perceptron_ctrl.md
# perceptron_ctrl

Controller for the perceptron branch predictor's weight table. It arbitrates between prediction lookups and training updates from the pipeline. For each accepted request it sequences a single-port row-wide weight memory. Predictions use a multi-cycle chunked dot product; training is a read-modify-write with saturating weight updates, gated by the misprediction/threshold rule.

## Interface
Parameters:
- PERCEPTRON_NUMBER, 62, weights per row and history bits per request
- WIDTH, 8, signed weight width
- TABLE_DEPTH, 64, rows in weight memory; IDX_W = $clog2(TABLE_DEPTH)
- LANES, 8, weights accumulated per cycle; K = ceil(PERCEPTRON_NUMBER/LANES)
- THETA, 133, training threshold

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-high: asserted at 1 despite the suffix
- pred_req_valid / pred_req_ready  in/out  1  prediction request handshake
- pred_idx  in  IDX_W  row to read
- pred_history  in  PERCEPTRON_NUMBER  global history; bit i=1 adds +w[i], 0 adds -w[i]
- pred_resp_valid  out  1  one-cycle result pulse
- pred_resp_taken  out  1  sum >= 0
- pred_resp_sum  out  32 signed  dot-product sum
- train_req_valid / train_req_ready  in/out  1  training request handshake
- train_idx  in  IDX_W; train_history  in  PERCEPTRON_NUMBER; train_outcome  in  1  resolved direction
- train_pred  in 1, train_sum  in 32 signed: prediction and sum originally returned
- train_done  out  1  one-cycle completion pulse (update or skip)
- wt_rd_en  out 1; wt_addr  out IDX_W; wt_rd_data  in  PERCEPTRON_NUMBER*WIDTH  valid the cycle after wt_rd_en
- wt_wr_en  out 1; wt_wr_data  out  PERCEPTRON_NUMBER*WIDTH  written at wt_addr

## Operation
- FSM states: IDLE, READ, CAPT, ACC, RESP, WRITE, DONE. One request in flight; no pipelining.
- train_req_ready = (state==IDLE); pred_req_ready = (state==IDLE) && !train_req_valid. Training has fixed priority on simultaneous valids.
- Accept latches idx, history and, for training, outcome/pred/sum.
- Predict path: IDLE→READ (wt_rd_en=1, wt_addr=idx)→CAPT (row register ← wt_rd_data, sum←0)→ACC for K cycles. Chunk j adds terms LANES*j..LANES*j+LANES-1; lanes ≥ PERCEPTRON_NUMBER in the last chunk add 0. Then RESP (pred_resp_valid=1)→IDLE.
- Arithmetic: weights sign-extended to 32 bits; -w of -2^(WIDTH-1) is computed in 32 bits with no wrap; sum is 32-bit signed and never overflows at legal parameters.
- Train decision at accept:
  - Update if train_pred != train_outcome, or -THETA <= train_sum <= THETA.
  - Otherwise skip: IDLE→DONE with no memory access.
- Train update path: READ→CAPT→WRITE→DONE.
  - In WRITE: wt_wr_en=1 at the latched idx. Each weight gets +1 if history[i]==outcome, else -1.
  - Each result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- wt_rd_en and wt_wr_en are never asserted in the same cycle. wt_addr holds the latched idx from READ through WRITE.

## Timing
- Predict accepted at cycle T: wt_rd_en at T+1, capture T+2, ACC T+3..T+2+K, pred_resp_valid at T+3+K (T+11 at defaults). pred_req_ready returns at T+4+K.
- Train update accepted at T: wt_rd_en T+1, capture T+2, wt_wr_en T+3, train_done T+4, ready again T+5.
- Train skip accepted at T: train_done T+1, ready T+2.
- pred_resp_taken and pred_resp_sum are held from RESP until the next RESP.
- While rst_n=1, the block asynchronously goes to IDLE. Outputs during and after reset:
  - Both readies 0 while reset is asserted.
  - pred_resp_valid, pred_resp_taken, pred_resp_sum, train_done, wt_rd_en and wt_wr_en all 0; internal sum and row register 0.
- Reset mid-operation drops the in-flight request; no partial write is issued. The first accept is possible in the first cycle after deassertion.

## Structure
- perceptron_pkg holds:
  - Defaults for PERCEPTRON_NUMBER, WIDTH, THETA and LANES.
  - weight_t (signed WIDTH), row_t (array of weight_t), sum_t (signed 32).
  - The ctrl_state_e enum.
- Sub-module perceptron_row_update: combinational row_t in, history, outcome → saturated row_t out.

## Test plan
- Row all +1, history all 1s, predict: pred_resp_sum=62, taken=1, valid at T+11; history all 0s gives -62, taken=0.
- Predict and train valid in the same cycle: train accepted first, predict accepted at T+5 with pred_req_ready low until then.
- Train with pred=1, outcome=1, sum=200: train_done at T+1, no wt_rd_en/wt_wr_en; sum=133 instead performs the update.
- Saturation: row weights 127 and -128; train outcome=1 with history bit i=1 for 127 and 0 for -128 → written row keeps 127 and -128. The opposite history gives 126 and -127.
- Mispredict with |sum|=500 still updates. A following predict of the same idx returns the sum shifted by exactly 62 toward the outcome.
- Assert rst_n during ACC: no pred_resp_valid, all outputs 0. After release, a new predict completes normally in 11 cycles.
